field_dispatch: RTL and testbench
=================================

Name: field_dispatch

Overview:
- Scheduler upstream of the output-ordering FSM. Accepts parsed protobuf field descriptors and dispatches each one as a command to either the varint decoder command FIFO or the raw-data decoder command FIFO.
- Every command carries the output slot index of its message. All fields of one message share an index; the index advances after the field flagged last.
- Credit-limits in-flight messages against retire pulses from the output-ordering FSM so that FSM's index/index+1 comparison never aliases on wrap.

Parameters:
INDEX_W, 10, width of output slot index (wraps at 2^INDEX_W-1 -> 0)
MAX_OUTSTANDING, 512, max messages dispatched-but-not-retired; must be <= 2^(INDEX_W-1)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
fld_valid  input  1  descriptor valid; held stable until fld_accepted
fld_wire_type  input  3  protobuf wire type: 0 varint, 1 fixed64, 2 length-delimited, 5 fixed32
fld_last  input  1  field is last of its message
fld_accepted  output  1  one-cycle pulse: descriptor consumed
varint_cmd_full  input  1  varint command FIFO full
varint_cmd_push  output  1  push to varint command FIFO
raw_cmd_full  input  1  raw command FIFO full
raw_cmd_push  output  1  push to raw command FIFO
cmd_index  output  INDEX_W  slot index accompanying either push
cmd_wire_type  output  3  registered copy of the wire type, for the raw decoder length select
retire  input  1  one-cycle pulse when the output FSM advances its index
outstanding  output  INDEX_W+1  current in-flight message count
err  output  2  sticky: bit0 unsupported wire type, bit1 retire underflow

Behaviour:
- One clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values: all outputs 0; state INIT; index 0; outstanding 0; err 0.
- Reset asserted mid-dispatch aborts immediately; no push occurs.
- Encoding: one-hot states INIT, WAIT_FLD, V_DISP, R_DISP, DROP. Moore outputs decoded from state; registered capture of wire_type and last.
- INIT: -> WAIT_FLD unconditionally; index and outstanding cleared.
- WAIT_FLD: evaluate in priority order.
  - No fld_valid: stay.
  - Wire type in {3,4,6,7}: capture, -> DROP.
  - outstanding == MAX_OUTSTANDING: stay (credit stall, nothing consumed).
  - Type 0 and !varint_cmd_full: capture, -> V_DISP.
  - Type in {1,2,5} and !raw_cmd_full: capture, -> R_DISP.
  - Otherwise stay.
- V_DISP: varint_cmd_push=1, fld_accepted=1, cmd_index=index; -> WAIT_FLD.
- R_DISP: raw_cmd_push=1, fld_accepted=1, cmd_index=index; -> WAIT_FLD.
- DROP: fld_accepted=1, err[0] set, no push; -> WAIT_FLD. If captured last=1, the index still advances so message slots stay aligned.
- Index update: on the dispatch/drop cycle with captured last=1, index <= (index==2^INDEX_W-1) ? 0 : index+1, effective the next cycle. cmd_index on the push cycle shows the pre-increment value.
- Outstanding counter:
  - +1 on a last-field dispatch/drop cycle; -1 on a retire pulse.
  - Both in the same cycle: unchanged.
  - retire at outstanding==0: counter holds at 0, err[1] set.
- Throughput and latency: one field per 2 cycles. fld_valid sampled in WAIT_FLD produces push/accepted on the next cycle. Upstream may present a new descriptor on the cycle after accepted.
- Full flags are sampled only in WAIT_FLD. A push in V_DISP/R_DISP is guaranteed safe because the FIFO had room when sampled.
- No other state changes index or outstanding.

Decomposition:
- Shared package: wire-type constants (WT_VARINT=0, WT_FIXED64=1, WT_LEN=2, WT_FIXED32=5), one-hot state constants, INDEX_W default.
- One sub-module is natural: slot_credit_counter, holding the outstanding up/down counter, saturation at 0, underflow flag and at-max compare.

Test Plan:
- Reset, then 3 fields {type0, type2, type0 last} -> pushes varint@idx0, raw@idx0, varint@idx0; index becomes 1; outstanding=1; fld_accepted on cycles 2, 4, 6.
- Hold varint_cmd_full=1 for 5 cycles with a type0 field valid -> no push, no accepted; push on the 2nd cycle after full drops.
- Preload index to 1023, dispatch a last field -> cmd_index=1023; next field cmd_index=0.
- Dispatch 512 single-field messages with no retire -> 513th field stalls. One retire pulse -> the field dispatches on the following 2 cycles. Coincident retire and last dispatch -> outstanding unchanged.
- Field type 3 with last=1 -> no push, fld_accepted pulses, err=01, index advances by 1.
- retire at outstanding=0 -> err=10 and outstanding stays 0. Assert reset_n low mid-V_DISP -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/field_dispatch_pkg.sv
// rtl/field_dispatch_pkg.sv - shared constants and helpers for the field dispatcher
//
// Purpose: protobuf wire-type codes, one-hot FSM state encodings and default
// widths used by field_dispatch and its credit counter.
package field_dispatch_pkg;

    localparam int INDEX_W_DEF         = 10;
    localparam int MAX_OUTSTANDING_DEF = 512;

    localparam logic [2:0] WT_VARINT  = 3'd0;
    localparam logic [2:0] WT_FIXED64 = 3'd1;
    localparam logic [2:0] WT_LEN     = 3'd2;
    localparam logic [2:0] WT_FIXED32 = 3'd5;

    // One-hot state bit positions and the matching state vectors.
    localparam int S_INIT     = 0;
    localparam int S_WAIT_FLD = 1;
    localparam int S_V_DISP   = 2;
    localparam int S_R_DISP   = 3;
    localparam int S_DROP     = 4;

    localparam logic [4:0] ST_INIT     = 5'b00001;
    localparam logic [4:0] ST_WAIT_FLD = 5'b00010;
    localparam logic [4:0] ST_V_DISP   = 5'b00100;
    localparam logic [4:0] ST_R_DISP   = 5'b01000;
    localparam logic [4:0] ST_DROP     = 5'b10000;

    // Wire types handled by the raw-data decoder.
    function automatic logic wt_is_raw(input logic [2:0] wt);
        return (wt == WT_FIXED64) || (wt == WT_LEN) || (wt == WT_FIXED32);
    endfunction

    // Group/deprecated and undefined wire types: consumed but never decoded.
    function automatic logic wt_is_unsupported(input logic [2:0] wt);
        return (wt != WT_VARINT) && !wt_is_raw(wt);
    endfunction

endpackage

// File: rtl/field_dispatch_slot_credit_counter.sv
// rtl/field_dispatch_slot_credit_counter.sv - in-flight message up/down counter
//
// Purpose: counts messages dispatched but not yet retired, saturating at zero.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   clear_i        synchronous clear to zero (FSM INIT)
//   inc_i          one message fully dispatched
//   dec_i          one message retired downstream
//   count_o        current in-flight count
//   at_max_o       count equals MAX_COUNT (dispatch must stall)
//   underflow_o    one-cycle pulse: retire seen with nothing in flight
module field_dispatch_slot_credit_counter #(
    parameter int CNT_W     = 11,
    parameter int MAX_COUNT = 512
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_max_o,
    output logic             underflow_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d     = count_q;
        underflow_o = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            // A retire with nothing in flight is an upstream bug: hold at zero and flag it.
            if (count_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign at_max_o = (count_q == CNT_W'(MAX_COUNT));

endmodule

// File: rtl/field_dispatch.sv
// rtl/field_dispatch.sv - dispatches protobuf field descriptors to decoder command FIFOs
//
// Purpose: routes each field descriptor to the varint or raw decoder command
// FIFO, tagging it with its message's output slot index, and credit-limits the
// number of messages in flight against retire pulses.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   fld_valid/wire_type/last      descriptor handshake in; fld_accepted pulses on consume
//   varint_cmd_full/push          varint command FIFO flow control / push
//   raw_cmd_full/push             raw command FIFO flow control / push
//   cmd_index, cmd_wire_type      payload accompanying either push
//   retire                        output FSM advanced its slot index
//   outstanding                   in-flight message count
//   err                           sticky: bit0 unsupported wire type, bit1 retire underflow
module field_dispatch
    import field_dispatch_pkg::*;
#(
    parameter int INDEX_W         = INDEX_W_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               fld_valid,
    input  logic [2:0]         fld_wire_type,
    input  logic               fld_last,
    output logic               fld_accepted,
    input  logic               varint_cmd_full,
    output logic               varint_cmd_push,
    input  logic               raw_cmd_full,
    output logic               raw_cmd_push,
    output logic [INDEX_W-1:0] cmd_index,
    output logic [2:0]         cmd_wire_type,
    input  logic               retire,
    output logic [INDEX_W:0]   outstanding,
    output logic [1:0]         err
);

    logic [4:0]         state_q, state_d;
    logic [2:0]         wt_q, wt_d;
    logic               last_q, last_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [1:0]         err_q, err_d;

    logic consuming;
    logic msg_done;
    logic credit_at_max;
    logic credit_underflow;

    // Any of the three one-cycle consume states closes out the captured field.
    assign consuming = state_q[S_V_DISP] | state_q[S_R_DISP] | state_q[S_DROP];
    // Dropped last fields also close their message so slot numbering stays aligned.
    assign msg_done  = consuming & last_q;

    field_dispatch_slot_credit_counter #(
        .CNT_W    (INDEX_W + 1),
        .MAX_COUNT(MAX_OUTSTANDING)
    ) u_slot_credit_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_i    (state_q[S_INIT]),
        .inc_i      (msg_done),
        .dec_i      (retire),
        .count_o    (outstanding),
        .at_max_o   (credit_at_max),
        .underflow_o(credit_underflow)
    );

    always_comb begin
        state_d = state_q;
        wt_d    = wt_q;
        last_d  = last_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_WAIT_FLD;
            end
            ST_WAIT_FLD: begin
                // Unsupported types are drained even under a credit stall so a
                // bad descriptor never blocks the stream.
                if (fld_valid) begin
                    if (wt_is_unsupported(fld_wire_type)) begin
                        wt_d    = fld_wire_type;
                        last_d  = fld_last;
                        state_d = ST_DROP;
                    end else if (credit_at_max) begin
                        state_d = ST_WAIT_FLD;
                    end else if ((fld_wire_type == WT_VARINT) && !varint_cmd_full) begin
                        wt_d    = fld_wire_type;
                        last_d  = fld_last;
                        state_d = ST_V_DISP;
                    end else if (wt_is_raw(fld_wire_type) && !raw_cmd_full) begin
                        wt_d    = fld_wire_type;
                        last_d  = fld_last;
                        state_d = ST_R_DISP;
                    end
                end
            end
            ST_V_DISP, ST_R_DISP, ST_DROP: begin
                state_d = ST_WAIT_FLD;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_comb begin
        index_d = index_q;
        if (state_q[S_INIT]) begin
            index_d = '0;
        end else if (msg_done) begin
            index_d = (index_q == {INDEX_W{1'b1}}) ? '0 : index_q + INDEX_W'(1);
        end
    end

    assign err_d = err_q | {credit_underflow, state_q[S_DROP]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            wt_q    <= '0;
            last_q  <= 1'b0;
            index_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            wt_q    <= wt_d;
            last_q  <= last_d;
            index_q <= index_d;
            err_q   <= err_d;
        end
    end

    // Moore outputs; cmd_index shows the pre-increment slot during the push.
    assign varint_cmd_push = state_q[S_V_DISP];
    assign raw_cmd_push    = state_q[S_R_DISP];
    assign fld_accepted    = consuming;
    assign cmd_index       = (state_q[S_V_DISP] | state_q[S_R_DISP]) ? index_q : '0;
    assign cmd_wire_type   = wt_q;
    assign err             = err_q;

endmodule

// File: tb/tb_field_dispatch.sv
// tb/tb_field_dispatch.sv - directed self-checking bench for field_dispatch
module tb_field_dispatch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fld_valid;
    logic [2:0]  fld_wire_type;
    logic        fld_last;
    logic        fld_accepted;
    logic        varint_cmd_full;
    logic        varint_cmd_push;
    logic        raw_cmd_full;
    logic        raw_cmd_push;
    logic [9:0]  cmd_index;
    logic [2:0]  cmd_wire_type;
    logic        retire;
    logic [10:0] outstanding;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    field_dispatch #(.INDEX_W(10), .MAX_OUTSTANDING(512)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fld_valid      (fld_valid),
        .fld_wire_type  (fld_wire_type),
        .fld_last       (fld_last),
        .fld_accepted   (fld_accepted),
        .varint_cmd_full(varint_cmd_full),
        .varint_cmd_push(varint_cmd_push),
        .raw_cmd_full   (raw_cmd_full),
        .raw_cmd_push   (raw_cmd_push),
        .cmd_index      (cmd_index),
        .cmd_wire_type  (cmd_wire_type),
        .retire         (retire),
        .outstanding    (outstanding),
        .err            (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        fld_valid       = 1'b0;
        fld_wire_type   = 3'd0;
        fld_last        = 1'b0;
        varint_cmd_full = 1'b0;
        raw_cmd_full    = 1'b0;
        retire          = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    // kind: 0 varint push, 1 raw push, 2 drop. ret drives retire during the consume cycle.
    task automatic send(input string tag, input logic [2:0] wt, input logic last, input int kind,
                        input logic [9:0] exp_idx, input logic ret, output int acc_cyc);
        int n;
        fld_valid     = 1'b1;
        fld_wire_type = wt;
        fld_last      = last;
        step();
        n = 0;
        while (!fld_accepted && n < 40) begin
            step();
            n++;
        end
        acc_cyc = cyc;
        check({tag, " accepted"}, 32'(fld_accepted), 32'd1);
        check({tag, " varint_push"}, 32'(varint_cmd_push), 32'(kind == 0));
        check({tag, " raw_push"}, 32'(raw_cmd_push), 32'(kind == 1));
        if (kind != 2) check({tag, " cmd_index"}, 32'(cmd_index), 32'(exp_idx));
        check({tag, " cmd_wire_type"}, 32'(cmd_wire_type), 32'(wt));
        fld_valid = 1'b0;
        fld_last  = 1'b0;
        retire    = ret;
        step();
        retire = 1'b0;
        check({tag, " accepted_pulse"}, 32'(fld_accepted), 32'd0);
    endtask

    initial begin
        int a0, a1, a2;

        // Reset state
        reset_n         = 1'b0;
        fld_valid       = 1'b0;
        fld_wire_type   = 3'd0;
        fld_last        = 1'b0;
        varint_cmd_full = 1'b0;
        raw_cmd_full    = 1'b0;
        retire          = 1'b0;
        step();
        check("rst accepted", 32'(fld_accepted), 32'd0);
        check("rst vpush", 32'(varint_cmd_push), 32'd0);
        check("rst rpush", 32'(raw_cmd_push), 32'd0);
        check("rst cmd_index", 32'(cmd_index), 32'd0);
        check("rst outstanding", 32'(outstanding), 32'd0);
        check("rst err", 32'(err), 32'd0);
        do_reset();

        // Three-field message: varint, raw, varint(last), one field per 2 cycles
        send("t1f0", 3'd0, 1'b0, 0, 10'd0, 1'b0, a0);
        send("t1f1", 3'd2, 1'b0, 1, 10'd0, 1'b0, a1);
        send("t1f2", 3'd0, 1'b1, 0, 10'd0, 1'b0, a2);
        check("t1 gap01", 32'(a1 - a0), 32'd2);
        check("t1 gap12", 32'(a2 - a1), 32'd2);
        check("t1 outstanding", 32'(outstanding), 32'd1);

        // varint FIFO full stall
        fld_valid       = 1'b1;
        fld_wire_type   = 3'd0;
        fld_last        = 1'b0;
        varint_cmd_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("vfull accepted", 32'(fld_accepted), 32'd0);
            check("vfull push", 32'(varint_cmd_push), 32'd0);
        end
        varint_cmd_full = 1'b0;
        step();
        check("vfull release push", 32'(varint_cmd_push), 32'd1);
        check("vfull release index", 32'(cmd_index), 32'd1);
        fld_valid = 1'b0;
        step();

        // raw FIFO full stall
        fld_valid     = 1'b1;
        fld_wire_type = 3'd5;
        raw_cmd_full  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rfull accepted", 32'(fld_accepted), 32'd0);
        end
        raw_cmd_full = 1'b0;
        step();
        check("rfull release push", 32'(raw_cmd_push), 32'd1);
        check("rfull release wt", 32'(cmd_wire_type), 32'd5);
        fld_valid = 1'b0;
        step();

        // Unsupported wire type with last: drop, err[0], index advances
        send("drop", 3'd3, 1'b1, 2, 10'd0, 1'b0, a0);
        check("drop err", 32'(err), 32'd1);
        check("drop outstanding", 32'(outstanding), 32'd2);
        send("after_drop", 3'd0, 1'b0, 0, 10'd2, 1'b0, a0);

        // Index wrap: 1023 messages each retired coincidentally with dispatch
        do_reset();
        for (int i = 0; i < 1023; i++) begin
            send("wrap_fill", 3'd0, 1'b1, 0, 10'(i), 1'b1, a0);
        end
        check("coincident outstanding", 32'(outstanding), 32'd0);
        check("coincident err", 32'(err), 32'd0);
        send("wrap_top", 3'd1, 1'b1, 1, 10'd1023, 1'b0, a0);
        check("wrap_top outstanding", 32'(outstanding), 32'd1);
        send("wrap_zero", 3'd0, 1'b0, 0, 10'd0, 1'b0, a0);

        // Credit limit: fill to 512 in flight
        for (int i = 0; i < 511; i++) begin
            send("credit_fill", 3'd0, 1'b1, 0, 10'(i), 1'b0, a0);
        end
        check("credit full count", 32'(outstanding), 32'd512);
        fld_valid     = 1'b1;
        fld_wire_type = 3'd0;
        fld_last      = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("credit stall accepted", 32'(fld_accepted), 32'd0);
        end
        retire = 1'b1;
        step();
        retire = 1'b0;
        check("credit after retire count", 32'(outstanding), 32'd511);
        check("credit after retire accepted", 32'(fld_accepted), 32'd0);
        step();
        check("credit resume push", 32'(varint_cmd_push), 32'd1);
        check("credit resume index", 32'(cmd_index), 32'd511);
        fld_valid = 1'b0;
        fld_last  = 1'b0;
        retire    = 1'b1;
        step();
        retire = 1'b0;
        check("credit coincident count", 32'(outstanding), 32'd511);

        // Retire underflow
        do_reset();
        retire = 1'b1;
        step();
        retire = 1'b0;
        check("underflow err", 32'(err), 32'd2);
        check("underflow outstanding", 32'(outstanding), 32'd0);

        // Asynchronous reset in the middle of V_DISP
        send("pre_abort", 3'd0, 1'b1, 0, 10'd0, 1'b0, a0);
        fld_valid     = 1'b1;
        fld_wire_type = 3'd0;
        fld_last      = 1'b1;
        step();
        check("abort in vdisp", 32'(varint_cmd_push), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort vpush", 32'(varint_cmd_push), 32'd0);
        check("abort accepted", 32'(fld_accepted), 32'd0);
        check("abort cmd_index", 32'(cmd_index), 32'd0);
        check("abort outstanding", 32'(outstanding), 32'd0);
        check("abort err", 32'(err), 32'd0);
        fld_valid = 1'b0;
        step();
        check("abort held vpush", 32'(varint_cmd_push), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
